mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Arbitrates the single-port 16-bit main memory between the accumulator CPU's memory-stage port and a DMA/IO loader port. It sits between the requesters and the memory, driving the memory's address, write-data and write-enable lines. It returns read data to the owning requester one cycle later. Policy:
- Fixed CPU priority.
- A bounded-wait starvation guard for DMA.
- A CPU lock for read-modify-write sequences.

## Interface
- ADDR_WIDTH, 10, memory word-address width; upper request address bits are ignored.
- DATA_WIDTH, 16, data word width.
- MAX_WAIT, 4, number of consecutive denied DMA-request cycles before DMA wins one grant (range 1–15).

Ports:
- CLK  in  1  system clock, all state on rising edge.
- Reset  in  1  synchronous, active-low reset.
- CpuReq  in  1  CPU access request, held until granted.
- CpuWe  in  1  1 = write, 0 = read.
- CpuLock  in  1  with a granted access, keep CPU ownership for the following cycle.
- CpuAddr  in  16  word address.
- CpuWData  in  16  write data.
- CpuGnt  out  1  access accepted this cycle.
- CpuRValid  out  1  read data valid, one-cycle pulse.
- CpuRData  out  16  read data.
- DmaReq, DmaWe, DmaAddr, DmaWData  in  1/1/16/16  DMA equivalents; there is no lock input.
- DmaGnt, DmaRValid, DmaRData  out  1/1/16  DMA equivalents.
- MemAddr  out  ADDR_WIDTH  to the memory address input.
- MemData  out  DATA_WIDTH  to the memory data input.
- MemWe  out  1  memory write enable.
- MemQ  in  DATA_WIDTH  memory read data; valid one cycle after the address.
- Owner  out  2  0 = none, 1 = CPU, 2 = DMA, for the granted access this cycle.

## Operation
- **Handshake.** A transfer occurs in a cycle where Req && Gnt. The requester holds Addr/WData/We stable until that cycle. Gnt is combinational from the current state and Req.
- **States.**
  - ARB: normal arbitration.
  - LOCKED: the CPU owns the memory.
  - Transitions:
    - ARB → LOCKED on a CPU grant with CpuLock = 1.
    - LOCKED stays LOCKED while CpuLock = 1.
    - LOCKED → ARB on a cycle with CpuLock = 0.
    - While LOCKED, a CpuReq is granted immediately.
- **ARB priority.**
  - Only one Req: that requester is granted.
  - Both Req: CPU is granted, unless WaitCnt == MAX_WAIT, in which case DMA is granted.
- **WaitCnt (4-bit).**
  - Increments, saturating at MAX_WAIT, each cycle DmaReq = 1 and DmaGnt = 0.
  - Clears on a DMA grant, or when DmaReq = 0.
  - In LOCKED, DmaGnt = 0 and the counter still counts and saturates.
- **Memory drive.**
  - MemAddr = granted Addr[ADDR_WIDTH-1:0].
  - MemData = granted WData.
  - MemWe = Req && Gnt && We of the owner.
  - With no grant: MemWe = 0, and MemAddr/MemData hold their last values.
- **Read return.**
  - A granted read sets a one-cycle registered pending tag (owner).
  - The next cycle, that port's RValid = 1 and its RData is loaded from MemQ.
  - RData holds until that port's next read returns.
  - Writes produce no RValid.
- **Back-to-back.** A new grant is allowed every cycle. A read's return and the next grant overlap.
- **Reset.** A mid-operation reset discards any pending read return; no RValid is produced.

## Timing
- Grant latency: 0 cycles when uncontended.
- DMA worst-case wait: MAX_WAIT cycles under continuous CPU traffic, excluding LOCKED time.
- Read latency: 1 cycle. RValid appears in cycle N+1 for a grant in cycle N.
- Write takes effect at the rising edge ending grant cycle N.
- Reset values (applied on the edge with Reset = 0):
  - State = ARB, WaitCnt = 0, pending tag = none.
  - CpuGnt/DmaGnt/RValids = 0, RData = 0.
  - MemAddr = 0, MemData = 0, MemWe = 0, Owner = 0.
  - Gnt outputs are forced 0 while Reset = 0.

## Structure
- The shared package acc_pkg holds:
  - the arbiter state enum (ARB, LOCKED);
  - owner encoding constants (OWN_NONE = 0, OWN_CPU = 1, OWN_DMA = 2);
  - the default MAX_WAIT.
- One sub-module: dma_wait_counter, the saturating 4-bit counter with inc/clear inputs and an at_max output.

## Test plan
- **Solo CPU read.** CpuReq = 1, CpuWe = 0, CpuAddr = 16'h0005, memory[5] = 16'h1234 → CpuGnt = 1 in cycle 0; CpuRValid = 1 and CpuRData = 16'h1234 in cycle 1; Owner = 1 in cycle 0.
- **Contention.** Both Req held, CPU reads back-to-back, MAX_WAIT = 4 → CPU granted cycles 0–3, DMA granted cycle 4 (WaitCnt = 4), CPU granted cycle 5, WaitCnt = 0 after cycle 4.
- **Lock.** CPU read of 16'h0010 with CpuLock = 1, then a write with CpuLock = 0, while DmaReq is held → DmaGnt = 0 for both cycles; DMA is granted in the cycle after the unlocked write if WaitCnt == MAX_WAIT, or when CpuReq drops.
- **Address truncation.** DMA write DmaAddr = 16'hFC07, data 16'hBEEF → MemAddr = 10'h007, MemWe = 1; a later CPU read of 16'h0007 returns 16'hBEEF.
- **Reset mid-read.** CPU read granted in cycle 0, Reset = 0 sampled at the end of cycle 0 → CpuRValid = 0 in cycle 1; all outputs at reset values; WaitCnt = 0.
- **Write then read, same address, consecutive cycles.** DMA writes 16'h00AA to 16'h0020, then the CPU reads 16'h0020 → CpuRData = 16'h00AA, DmaRValid never asserted.

Source files
------------

// File: rtl/acc_pkg.sv
// acc_pkg: shared arbiter state enum, owner encodings and default DMA wait bound
package acc_pkg;
  typedef enum logic {ARB, LOCKED} arb_state_t;
  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_CPU = 2'd1;
  localparam logic [1:0] OWN_DMA = 2'd2;
  localparam int DEF_MAX_WAIT = 4;
endpackage

// File: rtl/dma_wait_counter.sv
// dma_wait_counter: saturating 4-bit denied-cycle counter; clk, rst_n (sync low), inc, clr in; at_max out
module dma_wait_counter
  import acc_pkg::*;
#(
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic at_max
);
  logic [3:0] cnt;
  assign at_max = cnt == 4'(MAX_WAIT);
  always_ff @(posedge clk)
    if (!rst_n || clr) cnt <= '0;
    else if (inc && !at_max) cnt <= cnt + 4'd1;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: CPU-priority memory arbiter with DMA starvation guard and CPU lock; cpu_*/dma_* request ports, mem_* memory drive, owner of this cycle's grant
module mem_arbiter
  import acc_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic                  cpu_lock,
  input  logic [15:0]           cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_gnt,
  output logic                  cpu_rvalid,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  input  logic                  dma_req,
  input  logic                  dma_we,
  input  logic [15:0]           dma_addr,
  input  logic [DATA_WIDTH-1:0] dma_wdata,
  output logic                  dma_gnt,
  output logic                  dma_rvalid,
  output logic [DATA_WIDTH-1:0] dma_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic [1:0]            owner
);
  arb_state_t state;
  logic [1:0] pend;
  logic at_max;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q, cpu_rdata_q, dma_rdata_q;
  logic unused_addr_hi;
  assign unused_addr_hi = ^{cpu_addr[15:ADDR_WIDTH], dma_addr[15:ADDR_WIDTH]};
  assign cpu_gnt = rst_n && cpu_req && (state == LOCKED || !(dma_req && at_max));
  assign dma_gnt = rst_n && state == ARB && dma_req && !cpu_gnt;
  assign owner = cpu_gnt ? OWN_CPU : dma_gnt ? OWN_DMA : OWN_NONE;
  assign mem_addr = cpu_gnt ? cpu_addr[ADDR_WIDTH-1:0] : dma_gnt ? dma_addr[ADDR_WIDTH-1:0] : addr_q;
  assign mem_data = cpu_gnt ? cpu_wdata : dma_gnt ? dma_wdata : data_q;
  assign mem_we = (cpu_gnt && cpu_we) || (dma_gnt && dma_we);
  assign cpu_rvalid = pend == OWN_CPU;
  assign dma_rvalid = pend == OWN_DMA;
  assign cpu_rdata = cpu_rvalid ? mem_q : cpu_rdata_q;
  assign dma_rdata = dma_rvalid ? mem_q : dma_rdata_q;
  dma_wait_counter #(.MAX_WAIT(MAX_WAIT)) u_wait (
    .clk(clk),
    .rst_n(rst_n),
    .inc(dma_req && !dma_gnt),
    .clr(!dma_req || dma_gnt),
    .at_max(at_max)
  );
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= ARB;
      pend <= OWN_NONE;
      addr_q <= '0;
      data_q <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      state <= (state == LOCKED ? cpu_lock : cpu_gnt && cpu_lock) ? LOCKED : ARB;
      pend <= cpu_gnt && !cpu_we ? OWN_CPU : dma_gnt && !dma_we ? OWN_DMA : OWN_NONE;
      if (cpu_gnt || dma_gnt) begin
        addr_q <= mem_addr;
        data_q <= mem_data;
      end
      if (cpu_rvalid) cpu_rdata_q <= mem_q;
      if (dma_rvalid) dma_rdata_q <= mem_q;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized and directed self-checking bench for mem_arbiter against a cycle-level reference model
module tb_mem_arbiter;
  localparam int AW = 10;
  localparam int DW = 16;
  localparam int MW = 4;
  logic clk = 0;
  logic rst_n = 0;
  logic cpu_req = 0, cpu_we = 0, cpu_lock = 0;
  logic [15:0] cpu_addr = 0;
  logic [DW-1:0] cpu_wdata = 0;
  logic dma_req = 0, dma_we = 0;
  logic [15:0] dma_addr = 0;
  logic [DW-1:0] dma_wdata = 0;
  logic cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid, mem_we;
  logic [DW-1:0] cpu_rdata, dma_rdata, mem_data, mem_q;
  logic [AW-1:0] mem_addr;
  logic [1:0] owner;
  logic [DW-1:0] mem [1024];
  logic [DW-1:0] ref_mem [1024];
  int tests = 0;
  int fails = 0;
  bit chk_en = 0;
  bit m_locked = 0;
  int m_wait = 0;
  int m_pend = 0;
  logic [AW-1:0] m_paddr = 0, m_laddr = 0;
  logic [DW-1:0] m_ldata = 0, m_chold = 0, m_dhold = 0;
  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_lock(cpu_lock), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we), .mem_q(mem_q), .owner(owner)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (mem_we === 1'b1) mem[mem_addr] <= mem_data;
    mem_q <= mem[mem_addr];
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic void model_gnt(output bit cg, output bit dg);
    dg = rst_n && !m_locked && dma_req && (!cpu_req || m_wait == MW);
    cg = rst_n && cpu_req && !dg;
  endfunction
  always @(negedge clk) begin
    bit cg, dg;
    if (chk_en) begin
      model_gnt(cg, dg);
      chk("cpu_gnt", cpu_gnt, cg);
      chk("dma_gnt", dma_gnt, dg);
      chk("owner", owner, cg ? 2'd1 : dg ? 2'd2 : 2'd0);
      chk("mem_we", mem_we, (cg && cpu_we) || (dg && dma_we));
      chk("mem_addr", mem_addr, cg ? cpu_addr[AW-1:0] : dg ? dma_addr[AW-1:0] : m_laddr);
      chk("mem_data", mem_data, cg ? cpu_wdata : dg ? dma_wdata : m_ldata);
      chk("cpu_rvalid", cpu_rvalid, m_pend == 1);
      chk("dma_rvalid", dma_rvalid, m_pend == 2);
      chk("cpu_rdata", cpu_rdata, m_pend == 1 ? ref_mem[m_paddr] : m_chold);
      chk("dma_rdata", dma_rdata, m_pend == 2 ? ref_mem[m_paddr] : m_dhold);
    end
  end
  always @(posedge clk) begin
    bit cg, dg;
    if (!rst_n) begin
      m_locked = 0; m_wait = 0; m_pend = 0; m_laddr = 0; m_ldata = 0; m_chold = 0; m_dhold = 0;
      chk_en = 1;
    end else begin
      model_gnt(cg, dg);
      if (m_pend == 1) m_chold = ref_mem[m_paddr];
      if (m_pend == 2) m_dhold = ref_mem[m_paddr];
      m_pend = 0;
      if (cg) begin
        m_laddr = cpu_addr[AW-1:0]; m_ldata = cpu_wdata;
        if (cpu_we) ref_mem[m_laddr] = cpu_wdata; else begin m_pend = 1; m_paddr = m_laddr; end
      end
      if (dg) begin
        m_laddr = dma_addr[AW-1:0]; m_ldata = dma_wdata;
        if (dma_we) ref_mem[m_laddr] = dma_wdata; else begin m_pend = 2; m_paddr = m_laddr; end
      end
      m_wait = (dg || !dma_req) ? 0 : (m_wait < MW ? m_wait + 1 : MW);
      m_locked = m_locked ? cpu_lock : (cg && cpu_lock);
    end
  end
  task automatic nxt;
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [5:0] ec, ed;
    bit g_c, g_d;
    for (int i = 0; i < 1024; i++) begin
      mem[i] = 16'(i * 16'h0101) ^ 16'h5A5A;
      ref_mem[i] = mem[i];
    end
    mem[5] = 16'h1234;
    ref_mem[5] = 16'h1234;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0005;
    @(negedge clk);
    chk("solo_gnt", cpu_gnt, 1);
    chk("solo_owner", owner, 1);
    nxt; cpu_req = 0;
    @(negedge clk);
    chk("solo_rvalid", cpu_rvalid, 1);
    chk("solo_rdata", cpu_rdata, 16'h1234);
    nxt; dma_req = 1; dma_we = 1; dma_addr = 16'hFC07; dma_wdata = 16'hBEEF;
    @(negedge clk);
    chk("trunc_gnt", dma_gnt, 1);
    chk("trunc_addr", mem_addr, 10'h007);
    chk("trunc_we", mem_we, 1);
    nxt; dma_req = 0; cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0007;
    nxt; cpu_req = 0;
    @(negedge clk);
    chk("trunc_rdata", cpu_rdata, 16'hBEEF);
    nxt; dma_req = 1; dma_we = 1; dma_addr = 16'h0020; dma_wdata = 16'h00AA;
    nxt; dma_req = 0; cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0020;
    @(negedge clk);
    chk("wr_rd_dvalid0", dma_rvalid, 0);
    nxt; cpu_req = 0;
    @(negedge clk);
    chk("wr_rd_rdata", cpu_rdata, 16'h00AA);
    chk("wr_rd_dvalid1", dma_rvalid, 0);
    nxt; cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0000; dma_req = 1; dma_we = 0; dma_addr = 16'h0030;
    ec = 6'b101111;
    ed = 6'b010000;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("cont_cpu", cpu_gnt, ec[k]);
      chk("cont_dma", dma_gnt, ed[k]);
      nxt; cpu_addr = 16'(k + 1);
    end
    cpu_req = 0; dma_req = 0;
    nxt; cpu_req = 1; cpu_we = 0; cpu_lock = 1; cpu_addr = 16'h0010; dma_req = 1; dma_we = 0; dma_addr = 16'h0040;
    @(negedge clk);
    chk("lock_cpu0", cpu_gnt, 1);
    chk("lock_dma0", dma_gnt, 0);
    nxt; cpu_we = 1; cpu_lock = 0; cpu_wdata = 16'h5555;
    @(negedge clk);
    chk("lock_cpu1", cpu_gnt, 1);
    chk("lock_dma1", dma_gnt, 0);
    nxt; cpu_req = 0; cpu_we = 0;
    @(negedge clk);
    chk("lock_dma2", dma_gnt, 1);
    chk("lock_owner2", owner, 2);
    nxt; dma_req = 0;
    nxt; cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0005;
    @(negedge clk);
    chk("rst_gnt", cpu_gnt, 1);
    #1 rst_n = 0;
    nxt; rst_n = 1; cpu_req = 0;
    @(negedge clk);
    chk("rst_rvalid", cpu_rvalid, 0);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_maddr", mem_addr, 0);
    chk("rst_mdata", mem_data, 0);
    chk("rst_owner", owner, 0);
    chk("rst_drdata", dma_rdata, 0);
    nxt;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      g_c = cpu_gnt;
      g_d = dma_gnt;
      nxt;
      if (!cpu_req || g_c) begin
        cpu_req = $urandom_range(0, 3) != 0;
        cpu_we = $urandom_range(0, 1) != 0;
        cpu_addr = 16'($urandom) & 16'hFC1F;
        cpu_wdata = 16'($urandom);
      end
      cpu_lock = $urandom_range(0, 2) == 0;
      if (!dma_req || g_d) begin
        dma_req = $urandom_range(0, 2) != 0;
        dma_we = $urandom_range(0, 1) != 0;
        dma_addr = 16'($urandom) & 16'hFC1F;
        dma_wdata = 16'($urandom);
      end
      rst_n = $urandom_range(0, 99) != 0;
    end
    rst_n = 1; cpu_req = 0; dma_req = 0;
    repeat (2) nxt;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
